// File: rtl/barrett_reduce.sv
// rtl/barrett_reduce.sv - 4-stage pipelined Barrett reduction of a 2*wQ-bit product modulo Q
// Optional: define BARRETT_RANGE_CHECK_EN to add oErr, flagging inputs >= Q*Q.
module barrett_reduce #(
  parameter int unsigned   wQ = 32,
  parameter int unsigned   wI = 2*wQ,
  parameter logic [wQ-1:0] Q  = 32'd2013265921
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iValid,
  output logic          oReady,
  input  logic [wI-1:0] iX,
  output logic          oValid,
  input  logic          iReady,
  output logic [wQ-1:0] oR
`ifdef BARRETT_RANGE_CHECK_EN
  ,
  output logic          oErr
`endif
);

  typedef logic [wQ-1:0] d_t;
  typedef logic [wQ+1:0] r_t;
  typedef logic [wI-1:0] w_t;

  localparam w_t Q_W  = w_t'(Q);
  localparam w_t MU   = (w_t'(1) << (2*wQ-2)) / Q_W;
  localparam r_t Q1_E = r_t'(Q);
  localparam r_t Q2_E = r_t'(Q) << 1;

  logic adv;
  logic v1_q, v2_q, v3_q, oValid_q;
  r_t   x1_q, x1_d, x2_q, x2_d, r_q, r_d;
  d_t   q1_q, q1_d, q3_q, q3_d, oR_q, oR_d;

  // A single enable freezes the whole pipe while the output is held.
  assign adv    = !oValid_q || iReady;
  assign oReady = adv;
  assign oValid = oValid_q;
  assign oR     = oR_q;

`ifdef BARRETT_RANGE_CHECK_EN
  localparam w_t QQ = Q_W * Q_W;
  logic err1_q, err2_q, err3_q, oErr_q;
  assign oErr = oErr_q;
`endif

  always_comb begin
    x1_d = iX[wQ+1:0];
    // Legal inputs have the top two bits clear; saturating keeps garbage inputs harmless.
    q1_d = (|iX[wI-1:wI-2]) ? '1 : iX[wI-3:wQ-2];
    x2_d = x1_q;
    q3_d = d_t'(({{wQ{1'b0}}, q1_q} * MU) >> wQ);
    // Only the low wQ+2 bits matter: the true remainder is below 3Q < 2^(wQ+1).
    r_d  = x2_q - r_t'({{wQ{1'b0}}, q3_q} * Q_W);
    if (r_q >= Q2_E) begin
      oR_d = d_t'(r_q - Q2_E);
    end else if (r_q >= Q1_E) begin
      oR_d = d_t'(r_q - Q1_E);
    end else begin
      oR_d = d_t'(r_q);
    end
`ifdef BARRETT_RANGE_CHECK_EN
    if (err3_q) oR_d = '0;
`endif
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      oValid_q <= 1'b0;
      x1_q     <= '0;
      x2_q     <= '0;
      q1_q     <= '0;
      q3_q     <= '0;
      r_q      <= '0;
      oR_q     <= '0;
    end else if (adv) begin
      v1_q     <= iValid;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      oValid_q <= v3_q;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      q1_q     <= q1_d;
      q3_q     <= q3_d;
      r_q      <= r_d;
      oR_q     <= oR_d;
    end
  end

`ifdef BARRETT_RANGE_CHECK_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
      err3_q <= 1'b0;
      oErr_q <= 1'b0;
    end else if (adv) begin
      err1_q <= (iX >= QQ);
      err2_q <= err1_q;
      err3_q <= err2_q;
      oErr_q <= err3_q;
    end
  end
`endif

endmodule

// File: tb/tb_barrett_reduce.sv
// tb/tb_barrett_reduce.sv - scoreboard bench for barrett_reduce against a plain x mod Q model
module tb_barrett_reduce;

  localparam logic [63:0] QV = 64'd2013265921;

  logic        iClk = 1'b0;
  logic        iRst, iValid, iReady, oReady, oValid;
  logic [63:0] iX;
  logic [31:0] oR;
`ifdef BARRETT_RANGE_CHECK_EN
  logic        oErr;
`endif

  barrett_reduce dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iX     (iX),
    .oValid (oValid),
    .iReady (iReady),
    .oR     (oR)
`ifdef BARRETT_RANGE_CHECK_EN
    ,
    .oErr   (oErr)
`endif
  );

  typedef struct {
    logic [31:0] r;
    logic        e;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          chk_lat = 0;
  bit          stalled = 0;
  logic [31:0] hold_r;
  logic        hold_e;

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [63:0] x);
    exp_t m;
    m.cyc = cyc;
`ifdef BARRETT_RANGE_CHECK_EN
    m.e = (x >= QV * QV);
    m.r = m.e ? 32'd0 : 32'(x % QV);
`else
    m.e = 1'b0;
    m.r = 32'(x % QV);
`endif
    return m;
  endfunction

  function automatic logic cur_err();
`ifdef BARRETT_RANGE_CHECK_EN
    return oErr;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [63:0] x, input logic r, output bit acc);
    @(negedge iClk);
    iValid = v;
    iX     = x;
    iReady = r;
    #1;
    acc = v && oReady;
    if (acc) sb.push_back(model(x));
  endtask

  task automatic send(input logic [63:0] x, input bit rnd_ready);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    while (!acc && n < 100) begin
      drive(1'b1, x, rnd_ready ? ($urandom_range(3, 0) != 0) : 1'b1, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept after %0d cycles, expected accept", n);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      drive(1'b0, 64'd0, 1'b1, acc);
      #2;
      n++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on each consumed output, checks hold under stall.
  always @(negedge iClk) begin
    #2;
    if (iRst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(oValid), 64'd1);
        check("stall_data", 64'(oR), 64'(hold_r));
        check("stall_err", 64'(cur_err()), 64'(hold_e));
      end
      stalled = 0;
      if (oValid) begin
        if (iReady) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got oR=%0d with empty scoreboard, expected no output", oR);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 64'(oR), 64'(e.r));
            check("err_flag", 64'(cur_err()), 64'(e.e));
            if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd4);
          end
        end else begin
          stalled = 1;
          hold_r  = oR;
          hold_e  = cur_err();
        end
      end
    end
  end

  initial begin
    bit          acc;
    int          idx;
    int          k;
    logic [63:0] xs[5];
    logic [31:0] a, b;

    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iX = '0;
    repeat (2) @(negedge iClk);
    check("reset_valid", 64'(oValid), 64'd0);
    check("reset_data", 64'(oR), 64'd0);
    #3 iRst = 1'b0;
    #1 check("reset_ready", 64'(oReady), 64'd1);

    // Back-to-back directed values with exact latency.
    chk_lat = 1;
    drive(1'b1, 64'd0, 1'b1, acc);         check("accept0", 64'(acc), 64'd1);
    drive(1'b1, QV, 1'b1, acc);            check("accept1", 64'(acc), 64'd1);
    drive(1'b1, 64'd123456789, 1'b1, acc); check("accept2", 64'(acc), 64'd1);
    drive(1'b1, QV * QV - 64'd1, 1'b1, acc);
    drive(1'b1, (QV - 64'd1) * (QV - 64'd1), 1'b1, acc);
    drive(1'b1, 2 * QV + 64'd5, 1'b1, acc);
    drive(1'b1, 2 * QV - 64'd1, 1'b1, acc);
    drive(1'b1, 3 * QV - 64'd1, 1'b1, acc);
    drain();
    chk_lat = 0;

    // Five items with a three-cycle stall while the fifth waits for acceptance.
    for (int i = 0; i < 5; i++) begin
      a = $urandom_range(32'd2013265920, 0);
      b = $urandom_range(32'd2013265920, 0);
      xs[i] = 64'(a) * 64'(b);
    end
    idx = 0;
    k   = 0;
    while (idx < 5 && k < 50) begin
      drive(1'b1, xs[idx], !(k >= 4 && k < 7), acc);
      if (acc) idx++;
      k++;
    end
    check("stall_sent", 64'(idx), 64'd5);
    drain();

    // Reset with three items in flight, the first one held at the output.
    drive(1'b1, 64'd11, 1'b1, acc);
    drive(1'b1, 64'd22, 1'b1, acc);
    drive(1'b1, 64'd33, 1'b1, acc);
    drive(1'b0, 64'd0, 1'b1, acc);
    drive(1'b0, 64'd0, 1'b0, acc);
    #2 check("pre_reset_valid", 64'(oValid), 64'd1);
    iRst = 1'b1;
    #1;
    check("async_reset_valid", 64'(oValid), 64'd0);
    check("async_reset_data", 64'(oR), 64'd0);
    sb.delete();
    @(negedge iClk);
    #3 iRst = 1'b0;
    repeat (8) drive(1'b0, 64'd0, 1'b1, acc);
    chk_lat = 1;
    drive(1'b1, 64'd4026531847, 1'b1, acc);
    check("post_reset_accept", 64'(acc), 64'd1);
    drain();
    chk_lat = 0;

    // Random products with random bubbles and backpressure.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(32'd2013265920, 0);
      b = $urandom_range(32'd2013265920, 0);
      repeat ($urandom_range(2, 0)) drive(1'b0, 64'd0, ($urandom_range(3, 0) != 0), acc);
      send(64'(a) * 64'(b), 1'b1);
    end
    drain();

`ifdef BARRETT_RANGE_CHECK_EN
    send((64'd1 << 62) - 64'd1, 1'b0);
    send(QV * QV - 64'd1, 1'b0);
    send(QV * QV, 1'b0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
